// File: rtl/ps2_host_tx_if.sv
// Byte-transfer handshake between the port controller and the PS/2 host transmitter.
// master = port controller side, slave = transmitter side.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       done;
  logic [1:0] err;

  modport master (
    output tx_data,
    output tx_start,
    input  busy,
    input  done,
    input  err
  );

  modport slave (
    input  tx_data,
    input  tx_start,
    output busy,
    output done,
    output err
  );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 11-bit framing, ACK check, open-drain output enables.
// Optional frame watchdog is compiled in when PS2_TX_TIMEOUT_EN is defined.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN     = 8
) (
  input  logic clock,
  input  logic resetn,
  input  logic ps2_clk_i,
  input  logic ps2_dat_i,
  output logic ps2_clk_oe,
  output logic ps2_dat_oe,
  ps2_host_tx_if.slave tx
);

  localparam int CNT_W = $clog2(INHIBIT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    SEND,
    ACK,
    WAIT_IDLE
  } state_t;

  state_t state_q, state_d;

  logic [1:0]            clk_sync, dat_sync;
  logic [FILTER_LEN-1:0] clk_shift, dat_shift;
  logic                  clk_filt, dat_filt;
  logic                  clk_fall;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       idx_q, idx_d;
  logic [7:0]       data_q, data_d;
  logic             par_q, par_d;
  logic             clk_oe_q, clk_oe_d;
  logic             dat_oe_q, dat_oe_d;
  logic             done_q, done_d;
  logic [1:0]       err_q, err_d;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wdog_q, wdog_d;
`endif

  // Lines idle high, so the conditioning chain resets to 1 to avoid a phantom fall after reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clk_sync  <= 2'b11;
      dat_sync  <= 2'b11;
      clk_shift <= '1;
      dat_shift <= '1;
      clk_filt  <= 1'b1;
      dat_filt  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_i};
      dat_sync  <= {dat_sync[0], ps2_dat_i};
      clk_shift <= {clk_shift[FILTER_LEN-2:0], clk_sync[1]};
      dat_shift <= {dat_shift[FILTER_LEN-2:0], dat_sync[1]};
      if (&clk_shift)
        clk_filt <= 1'b1;
      else if (~|clk_shift)
        clk_filt <= 1'b0;
      if (&dat_shift)
        dat_filt <= 1'b1;
      else if (~|dat_shift)
        dat_filt <= 1'b0;
    end
  end

  // Combinational fall lets the FSM react on the same edge the filtered level drops.
  assign clk_fall = clk_filt & ~|clk_shift;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    data_d   = data_q;
    par_d    = par_q;
    clk_oe_d = clk_oe_q;
    dat_oe_d = dat_oe_q;
    done_d   = 1'b0;
    err_d    = err_q;
`ifdef PS2_TX_TIMEOUT_EN
    wdog_d   = wdog_q;
`endif

    case (state_q)
      IDLE: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        if (tx.tx_start) begin
          data_d   = tx.tx_data;
          par_d    = ~^tx.tx_data;
          cnt_d    = '0;
          err_d    = 2'b00;
          clk_oe_d = 1'b1;
          state_d  = INHIBIT;
        end
      end
      INHIBIT: begin
        if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
          dat_oe_d = 1'b1;
          state_d  = START;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      START: begin
        clk_oe_d = 1'b0;
        idx_d    = 4'd0;
`ifdef PS2_TX_TIMEOUT_EN
        wdog_d   = '0;
`endif
        state_d  = SEND;
      end
      SEND: begin
        if (clk_fall) begin
          if (idx_q < 4'd8) begin
            dat_oe_d = ~data_q[idx_q[2:0]];
          end else if (idx_q == 4'd8) begin
            dat_oe_d = ~par_q;
          end else begin
            dat_oe_d = 1'b0;
            state_d  = ACK;
          end
          idx_d = idx_q + 4'd1;
        end
      end
      ACK: begin
        if (clk_fall) begin
          err_d   = dat_filt ? 2'b01 : 2'b00;
          state_d = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (clk_filt && dat_filt) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    // Placed after the case so expiry overrides a coincident fall.
    if (state_q == SEND || state_q == ACK || state_q == WAIT_IDLE) begin
      if (wdog_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        err_d    = 2'b10;
        done_d   = 1'b1;
        state_d  = IDLE;
      end else begin
        wdog_d = wdog_q + WD_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= 4'd0;
      data_q   <= 8'd0;
      par_q    <= 1'b0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      par_q    <= par_d;
      clk_oe_q <= clk_oe_d;
      dat_oe_q <= dat_oe_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

`ifdef PS2_TX_TIMEOUT_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      wdog_q <= '0;
    else
      wdog_q <= wdog_d;
  end
`endif

  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;
  assign tx.busy    = (state_q != IDLE);
  assign tx.done    = done_q;
  assign tx.err     = err_q;

endmodule
